// File: rtl/bpu_pkg.sv
// Shared definitions for the tagged fetch-group branch predictor.
//   - branch-type encodings carried in the BTB and on the resolution ports
//   - 2-bit direction counter states and the saturating step helper
//   - default parameter values for bpu_tagged
package bpu_pkg;

    localparam int DEF_ENTRIES   = 32;
    localparam int DEF_FETCH_W   = 4;
    localparam int DEF_TAG_W     = 8;
    localparam int DEF_RAS_DEPTH = 8;

    typedef enum logic [1:0] {
        BR_COND = 2'b00,
        BR_JUMP = 2'b01,
        BR_CALL = 2'b10,
        BR_RET  = 2'b11
    } br_type_e;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    // Saturating 2-bit counter move toward ST (up) or SNT (down).
    function automatic logic [1:0] ctr_step(input logic [1:0] c, input logic up);
        if (up) return (c == CTR_ST) ? CTR_ST : c + 2'd1;
        else    return (c == CTR_SNT) ? CTR_SNT : c - 2'd1;
    endfunction

endpackage

// File: rtl/bpu_fold_hash.sv
// XOR-fold of an IN_W-bit value down to OUT_W bits: input bit i lands on
// output bit (i mod OUT_W); a short final chunk is effectively zero-padded.
// Ports:
//   i_in   IN_W   value to fold
//   o_out  OUT_W  folded result
module bpu_fold_hash #(
    parameter int IN_W  = 28,
    parameter int OUT_W = 5
) (
    input  logic [IN_W-1:0]  i_in,
    output logic [OUT_W-1:0] o_out
);

    logic [OUT_W-1:0] w_acc;

    always_comb begin
        w_acc = '0;
        for (int i = 0; i < IN_W; i++) begin
            w_acc[i % OUT_W] = w_acc[i % OUT_W] ^ i_in[i];
        end
    end

    assign o_out = w_acc;

endmodule

// File: rtl/bpu_tagged.sv
// Fetch-group branch predictor: tagged BTB with per-entry 2-bit counter and
// branch type, plus a return address stack trained at resolution.
// Lookup is combinational; two resolution channels (0 older than 1) update
// state on the clock edge.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   pc                    fetch PC (word aligned)
//   next_pc               predicted next fetch PC
//   pc_valid [FETCH_W]    lanes of the group to issue
//   pc_is_jump [FETCH_W]  one-hot predicted-taken lane, or 0
//   updN_valid/pc/taken/type/target  resolution channel N (N = 0, 1)
module bpu_tagged
    import bpu_pkg::*;
#(
    parameter int ENTRIES   = DEF_ENTRIES,
    parameter int FETCH_W   = DEF_FETCH_W,
    parameter int TAG_W     = DEF_TAG_W,
    parameter int RAS_DEPTH = DEF_RAS_DEPTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        pc,
    output logic [31:0]        next_pc,
    output logic [FETCH_W-1:0] pc_valid,
    output logic [FETCH_W-1:0] pc_is_jump,
    input  logic               upd0_valid,
    input  logic [31:0]        upd0_pc,
    input  logic               upd0_taken,
    input  logic [1:0]         upd0_type,
    input  logic [31:0]        upd0_target,
    input  logic               upd1_valid,
    input  logic [31:0]        upd1_pc,
    input  logic               upd1_taken,
    input  logic [1:0]         upd1_type,
    input  logic [31:0]        upd1_target
);

    localparam int OFF     = $clog2(FETCH_W) + 2;
    localparam int IDX_W   = $clog2(ENTRIES);
    localparam int LANE_W  = (FETCH_W > 1) ? $clog2(FETCH_W) : 1;
    localparam int RAS_W   = $clog2(RAS_DEPTH);
    localparam int CNT_W   = RAS_W + 1;
    localparam int HI_W    = 32 - OFF;
    localparam int TAGIN_W = 32 - OFF - IDX_W;

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [LANE_W-1:0] slot;
        br_type_e          typ;
        logic [1:0]        ctr;
        logic [29:0]       tgt;
    } entry_t;

    typedef struct packed {
        logic [RAS_W-1:0] ptr;
        logic [CNT_W-1:0] cnt;
    } ras_st_t;

    entry_t      r_btb [ENTRIES];
    logic [29:0] r_ras [RAS_DEPTH];
    ras_st_t     r_ras_st;

    // Index/tag/lane for the three PCs: 0 = lookup, 1 = upd0, 2 = upd1.
    logic [31:0]       w_hpc  [3];
    logic [IDX_W-1:0]  w_idx  [3];
    logic [TAG_W-1:0]  w_tag  [3];
    logic [LANE_W-1:0] w_lane [3];

    assign w_hpc[0] = pc;
    assign w_hpc[1] = upd0_pc;
    assign w_hpc[2] = upd1_pc;

    for (genvar g = 0; g < 3; g++) begin : g_hash
        assign w_lane[g] = LANE_W'((w_hpc[g] >> 2) & 32'(FETCH_W - 1));
        bpu_fold_hash #(.IN_W(HI_W), .OUT_W(IDX_W)) u_idx (
            .i_in  (w_hpc[g][31:OFF]),
            .o_out (w_idx[g])
        );
        bpu_fold_hash #(.IN_W(TAGIN_W), .OUT_W(TAG_W)) u_tag (
            .i_in  (w_hpc[g][31:OFF+IDX_W]),
            .o_out (w_tag[g])
        );
    end

    // ---------------- lookup ----------------
    entry_t           w_ent;
    logic             w_hit;
    logic             w_pred;
    logic [RAS_W-1:0] w_top;

    always_comb begin
        w_ent  = r_btb[w_idx[0]];
        w_top  = r_ras_st.ptr - RAS_W'(1);
        w_hit  = w_ent.valid && (w_ent.tag == w_tag[0]) && (w_ent.slot >= w_lane[0]);
        // A RET with nothing on the stack has no usable target.
        w_pred = w_hit && ((w_ent.typ != BR_COND) || w_ent.ctr[1])
                 && !((w_ent.typ == BR_RET) && (r_ras_st.cnt == '0));
        next_pc    = (pc & ~32'(FETCH_W * 4 - 1)) + 32'(FETCH_W * 4);
        pc_is_jump = '0;
        for (int i = 0; i < FETCH_W; i++) begin
            pc_valid[i] = (LANE_W'(i) >= w_lane[0]);
        end
        if (w_pred) begin
            next_pc = (w_ent.typ == BR_RET) ? {r_ras[w_top], 2'b00} : {w_ent.tgt, 2'b00};
            pc_is_jump[w_ent.slot] = 1'b1;
            for (int i = 0; i < FETCH_W; i++) begin
                pc_valid[i] = (LANE_W'(i) >= w_lane[0]) && (LANE_W'(i) <= w_ent.slot);
            end
        end
    end

    // ---------------- BTB training ----------------
    function automatic entry_t apply_upd(input entry_t e, input logic [TAG_W-1:0] tag,
                                         input logic [LANE_W-1:0] lane, input logic taken,
                                         input br_type_e typ, input logic [29:0] tgt);
        entry_t r;
        r = e;
        if (e.valid && (e.tag == tag)) begin
            if (typ == BR_COND) r.ctr = ctr_step(e.ctr, taken);
            if (taken) begin
                r.tgt  = tgt;
                r.typ  = typ;
                r.slot = lane;
                if (typ != BR_COND) r.ctr = CTR_ST;
            end
        end else if (taken) begin
            r.valid = 1'b1;
            r.tag   = tag;
            r.slot  = lane;
            r.typ   = typ;
            r.tgt   = tgt;
            r.ctr   = (typ == BR_COND) ? CTR_WT : CTR_ST;
        end
        return r;
    endfunction

    entry_t w_new0;
    entry_t w_base1;
    entry_t w_new1;

    // Channel 1 builds on channel 0's result when both hit the same index.
    always_comb begin
        w_new0  = apply_upd(r_btb[w_idx[1]], w_tag[1], w_lane[1], upd0_taken,
                            br_type_e'(upd0_type), 30'(upd0_target >> 2));
        w_base1 = (upd0_valid && (w_idx[1] == w_idx[2])) ? w_new0 : r_btb[w_idx[2]];
        w_new1  = apply_upd(w_base1, w_tag[2], w_lane[2], upd1_taken,
                            br_type_e'(upd1_type), 30'(upd1_target >> 2));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) r_btb[i].valid <= 1'b0;
        end else begin
            if (upd0_valid) r_btb[w_idx[1]] <= w_new0;
            if (upd1_valid) r_btb[w_idx[2]] <= w_new1;
        end
    end

    // ---------------- RAS training ----------------
    function automatic ras_st_t ras_step(input ras_st_t s, input logic push, input logic pop);
        ras_st_t n;
        n = s;
        if (push) begin
            // Full stack: pointer keeps moving, so the oldest slot is overwritten.
            n.ptr = s.ptr + RAS_W'(1);
            if (s.cnt != CNT_W'(RAS_DEPTH)) n.cnt = s.cnt + CNT_W'(1);
        end else if (pop && (s.cnt != '0)) begin
            n.ptr = s.ptr - RAS_W'(1);
            n.cnt = s.cnt - CNT_W'(1);
        end
        return n;
    endfunction

    logic    w_push0, w_pop0, w_push1, w_pop1;
    ras_st_t w_ras_a;
    ras_st_t w_ras_n;

    always_comb begin
        w_push0 = upd0_valid && (br_type_e'(upd0_type) == BR_CALL);
        w_pop0  = upd0_valid && (br_type_e'(upd0_type) == BR_RET);
        w_push1 = upd1_valid && (br_type_e'(upd1_type) == BR_CALL);
        w_pop1  = upd1_valid && (br_type_e'(upd1_type) == BR_RET);
        w_ras_a = ras_step(r_ras_st, w_push0, w_pop0);
        w_ras_n = ras_step(w_ras_a, w_push1, w_pop1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ras_st <= '0;
        end else begin
            r_ras_st <= w_ras_n;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (w_push0) r_ras[r_ras_st.ptr] <= 30'((upd0_pc + 32'd4) >> 2);
            if (w_push1) r_ras[w_ras_a.ptr]  <= 30'((upd1_pc + 32'd4) >> 2);
        end
    end

endmodule

// File: tb/tb_bpu_tagged.sv
module tb_bpu_tagged;
    import bpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic [3:0]  pc_valid;
    logic [3:0]  pc_is_jump;
    logic        upd0_valid, upd0_taken, upd1_valid, upd1_taken;
    logic [31:0] upd0_pc, upd0_target, upd1_pc, upd1_target;
    logic [1:0]  upd0_type, upd1_type;

    bpu_tagged #(.ENTRIES(32), .FETCH_W(4), .TAG_W(8), .RAS_DEPTH(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .pc          (pc),
        .next_pc     (next_pc),
        .pc_valid    (pc_valid),
        .pc_is_jump  (pc_is_jump),
        .upd0_valid  (upd0_valid),
        .upd0_pc     (upd0_pc),
        .upd0_taken  (upd0_taken),
        .upd0_type   (upd0_type),
        .upd0_target (upd0_target),
        .upd1_valid  (upd1_valid),
        .upd1_pc     (upd1_pc),
        .upd1_taken  (upd1_taken),
        .upd1_type   (upd1_type),
        .upd1_target (upd1_target)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [31:0] npc;
        logic [3:0]  v;
        logic [3:0]  j;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    logic look_vld = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, got, exp);
    endtask

    // Monitor: compares whenever a lookup is being presented.
    always @(negedge clk) begin
        if (look_vld) begin
            if (q.size() == 0) begin
                n_checks++;
                $display("FAIL scoreboard: lookup with no expected entry, got %h", next_pc);
            end else begin
                mon_e = q.pop_front();
                check({mon_e.nm, ".next_pc"}, next_pc, mon_e.npc);
                check({mon_e.nm, ".pc_valid"}, {28'd0, pc_valid}, {28'd0, mon_e.v});
                check({mon_e.nm, ".pc_is_jump"}, {28'd0, pc_is_jump}, {28'd0, mon_e.j});
            end
        end
    end

    task automatic look(input string nm, input logic [31:0] p, input logic [31:0] enpc,
                        input logic [3:0] ev, input logic [3:0] ej);
        exp_t e;
        e.nm = nm; e.npc = enpc; e.v = ev; e.j = ej;
        q.push_back(e);
        pc = p;
        look_vld = 1'b1;
        @(posedge clk); #1;
        look_vld = 1'b0;
    endtask

    task automatic set_upd(input int ch, input logic [31:0] p, input logic tk,
                           input br_type_e ty, input logic [31:0] tg);
        if (ch == 0) begin
            upd0_valid = 1'b1; upd0_pc = p; upd0_taken = tk; upd0_type = ty; upd0_target = tg;
        end else begin
            upd1_valid = 1'b1; upd1_pc = p; upd1_taken = tk; upd1_type = ty; upd1_target = tg;
        end
    endtask

    task automatic commit();
        @(posedge clk); #1;
        upd0_valid = 1'b0;
        upd1_valid = 1'b0;
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; pc = '0;
        upd0_valid = 0; upd0_pc = '0; upd0_taken = 0; upd0_type = '0; upd0_target = '0;
        upd1_valid = 0; upd1_pc = '0; upd1_taken = 0; upd1_type = '0; upd1_target = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        look("rst_ft", 32'h1C000008, 32'h1C000010, 4'b1100, 4'b0000);

        // COND branch in lane 1 of group 0x1C000100
        set_upd(0, 32'h1C000104, 1'b1, BR_COND, 32'h1C000200); commit();
        look("cond_hit", 32'h1C000100, 32'h1C000200, 4'b0011, 4'b0010);
        look("slot_lt_lane", 32'h1C000108, 32'h1C000110, 4'b1100, 4'b0000);

        // Counter walk 10 -> 01 -> 00 -> 01 -> 10
        set_upd(0, 32'h1C000104, 1'b0, BR_COND, 32'h1C000200); commit();
        set_upd(0, 32'h1C000104, 1'b0, BR_COND, 32'h1C000200); commit();
        look("ctr_00", 32'h1C000100, 32'h1C000110, 4'b1111, 4'b0000);
        set_upd(0, 32'h1C000104, 1'b1, BR_COND, 32'h1C000200); commit();
        look("ctr_01", 32'h1C000100, 32'h1C000110, 4'b1111, 4'b0000);
        set_upd(0, 32'h1C000104, 1'b1, BR_COND, 32'h1C000200); commit();
        look("ctr_10", 32'h1C000100, 32'h1C000200, 4'b0011, 4'b0010);

        // Double counter step from both channels on one entry
        set_upd(0, 32'h1C000604, 1'b1, BR_COND, 32'h1C000700); commit();
        look("c2_alloc", 32'h1C000600, 32'h1C000700, 4'b0011, 4'b0010);
        set_upd(0, 32'h1C000604, 1'b0, BR_COND, 32'h1C000700);
        set_upd(1, 32'h1C000604, 1'b0, BR_COND, 32'h1C000700); commit();
        look("c2_dec2", 32'h1C000600, 32'h1C000610, 4'b1111, 4'b0000);
        set_upd(0, 32'h1C000604, 1'b1, BR_COND, 32'h1C000700);
        set_upd(1, 32'h1C000604, 1'b1, BR_COND, 32'h1C000700); commit();
        look("c2_inc2", 32'h1C000600, 32'h1C000700, 4'b0011, 4'b0010);

        // RET entry trained while RAS is empty, then a CALL fills the RAS
        set_upd(0, 32'h1C000400, 1'b1, BR_RET, 32'h00000000); commit();
        look("ret_empty", 32'h1C000400, 32'h1C000410, 4'b1111, 4'b0000);
        set_upd(0, 32'h1C000300, 1'b1, BR_CALL, 32'h1C000800); commit();
        look("ret_ras", 32'h1C000400, 32'h1C000304, 4'b0001, 4'b0001);
        set_upd(0, 32'h1C000400, 1'b1, BR_RET, 32'h00000000); commit();
        look("ret_popped", 32'h1C000400, 32'h1C000410, 4'b1111, 4'b0000);

        // Both channels hit the same index; channel 1 fields win
        set_upd(0, 32'h1C000500, 1'b1, BR_JUMP, 32'h00001000);
        set_upd(1, 32'h1C000508, 1'b1, BR_JUMP, 32'h00002000); commit();
        look("same_idx_l0", 32'h1C000500, 32'h00002000, 4'b0111, 4'b0100);
        look("same_idx_l2", 32'h1C000508, 32'h00002000, 4'b0100, 4'b0100);

        // Nine CALLs (first two in one cycle, ch0 older) into an 8-deep RAS
        set_upd(0, 32'h1C002000, 1'b1, BR_CALL, 32'h1C00F000);
        set_upd(1, 32'h1C002010, 1'b1, BR_CALL, 32'h1C00F000); commit();
        for (int k = 2; k < 9; k++) begin
            set_upd(0, 32'h1C002000 + 32'(k * 16), 1'b1, BR_CALL, 32'h1C00F000); commit();
        end
        for (int j = 0; j < 8; j++) begin
            look($sformatf("ras_pop%0d", j), 32'h1C000400,
                 32'h1C002004 + 32'((8 - j) * 16), 4'b0001, 4'b0001);
            set_upd(0, 32'h1C000400, 1'b1, BR_RET, 32'h00000000); commit();
        end
        look("ras_drained", 32'h1C000400, 32'h1C000410, 4'b1111, 4'b0000);
        set_upd(0, 32'h1C000400, 1'b1, BR_RET, 32'h00000000); commit();
        look("ras_pop_ign", 32'h1C000400, 32'h1C000410, 4'b1111, 4'b0000);

        // Update coincident with reset: reset wins
        set_upd(0, 32'hFFFFFFF0, 1'b1, BR_JUMP, 32'h00001234);
        reset = 1'b1; commit();
        look("rst_wrap", 32'hFFFFFFF0, 32'h00000000, 4'b1111, 4'b0000);
        look("rst_cleared", 32'h1C000600, 32'h1C000610, 4'b1111, 4'b0000);

        for (int k = 0; k < 10 && q.size() != 0; k++) @(posedge clk);
        if (q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: %0d expected lookups never checked, required 0", q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
